hex_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that drives a bank of common-anode seven-segment digits through a single shared `hex` decoder instance. It latches a multi-digit hex value and steps through the digits at a fixed refresh rate, one digit per slot. For each digit it selects the nibble, drives the segments and asserts exactly one digit enable. It sits between the datapath result registers and the board display pins, and it replaces one decoder per digit.

---
 rtl/display_pkg.sv | 13 +
 rtl/hex.sv | 30 +++
 rtl/hex_scan_ctrl.sv | 107 ++++++++++
 tb/tb_hex_scan_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display types and constants for the seven-segment scan path.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {
    GUARD,
    DRIVE
  } scan_state_t;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/hex.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex (
  input  logic [3:0] in,
  output logic [6:0] out
);

  always_comb begin
    out = 7'h7F;
    case (in)
      4'h0: out = 7'h40;
      4'h1: out = 7'h79;
      4'h2: out = 7'h24;
      4'h3: out = 7'h30;
      4'h4: out = 7'h19;
      4'h5: out = 7'h12;
      4'h6: out = 7'h02;
      4'h7: out = 7'h78;
      4'h8: out = 7'h00;
      4'h9: out = 7'h10;
      4'hA: out = 7'h08;
      4'hB: out = 7'h03;
      4'hC: out = 7'h46;
      4'hD: out = 7'h21;
      4'hE: out = 7'h06;
      4'hF: out = 7'h0E;
      default: out = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed common-anode display scanner sharing one hex decoder.
// The displayed frame only changes on a frame boundary, so a load never tears a frame.
module hex_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  scan_state
);
  import display_pkg::SEG_OFF;
  import display_pkg::scan_state_t;
  import display_pkg::nibble_t;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] disp;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  scan_state_t         state;
  scan_state_t         state_nx;

  logic                cnt_last;
  logic                frame_end;
  nibble_t             nibble;
  logic [6:0]          dec_out;
  logic                upper_nz;
  logic                blank;
  logic [DIGITS-1:0]   an_nx;
  logic [6:0]          seg_nx;
  logic                dp_nx;

  assign cnt_last   = (cnt == CNT_LAST);
  assign frame_end  = cnt_last && (idx == IDX_LAST);
  assign nibble     = disp[{idx, 2'b00} +: 4];
  assign scan_state = state;

  hex u_hex (
    .in  (nibble),
    .out (dec_out)
  );

  // Digit idx is a leading zero when it and every more significant nibble is zero.
  always_comb begin
    upper_nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx) && disp[4*j +: 4] != 4'h0) upper_nz = 1'b1;
    end
    blank = blank_lz && (idx != '0) && !upper_nz;
  end

  always_comb begin
    state_nx = state;
    an_nx    = '1;
    seg_nx   = SEG_OFF;
    dp_nx    = 1'b1;
    case (state)
      display_pkg::GUARD: begin
        if (cnt == GUARD_LAST) state_nx = display_pkg::DRIVE;
      end
      display_pkg::DRIVE: begin
        if (cnt_last) state_nx = display_pkg::GUARD;
        an_nx  = ~(DIGITS'(1) << idx);
        seg_nx = blank ? SEG_OFF : dec_out;
        dp_nx  = ~dp_mask[idx];
      end
      default: state_nx = display_pkg::GUARD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      state  <= display_pkg::GUARD;
      shadow <= '0;
      disp   <= '0;
      an     <= '1;
      seg    <= SEG_OFF;
      dp     <= 1'b1;
    end else begin
      cnt   <= cnt_last ? '0 : cnt + CW'(1);
      if (cnt_last) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      state <= state_nx;
      if (load) shadow <= value;
      // A load landing on the boundary bypasses shadow so it shows next frame.
      if (frame_end) disp <= load ? value : shadow;
      an    <= an_nx;
      seg   <= seg_nx;
      dp    <= dp_nx;
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: directed and random stimulus against a frame-level display model.
module tb_hex_scan_ctrl;
  localparam int N_DIG = 4;
  localparam int P_DIV = 8;
  localparam int P_GRD = 2;
  localparam int FRAME = N_DIG * P_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        scan_state;

  int checks = 0;
  int fails  = 0;
  int t      = 0;
  logic [15:0] pending = '0;
  logic [15:0] shown   = '0;
  logic [11:0] exp_q[$];

  hex_scan_ctrl #(.DIGITS(N_DIG), .DIV(P_DIV), .GUARD(P_GRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .load       (load),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .scan_state (scan_state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected {an, seg, dp} produced by the cycle whose time index is tt.
  function automatic logic [11:0] model(input int tt, input logic [15:0] v,
                                        input logic [3:0] m, input logic b);
    int d;
    int pos;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        dp_e;
    logic [15:0] upper;
    pos = tt % P_DIV;
    d   = (tt / P_DIV) % N_DIG;
    if (pos < P_GRD) return {4'hF, 7'h7F, 1'b1};
    an_e  = ~(4'(1) << d);
    upper = v >> (4 * d);
    seg_e = (b && d != 0 && upper == 16'h0) ? 7'h7F : seg_of(upper[3:0]);
    dp_e  = ~m[d];
    return {an_e, seg_e, dp_e};
  endfunction

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] m, input logic b);
    logic [11:0] e;
    rst = r; load = ld; value = v; dp_mask = m; blank_lz = b;
    if (r) begin
      e = {4'hF, 7'h7F, 1'b1};
    end else begin
      if (t % FRAME == 0) shown = pending;
      e = model(t, shown, m, b);
      if (ld) pending = v;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (an === e[11:8]) else begin
      fails++;
      $error("FAIL an t=%0d observed=%h expected=%h", t, an, e[11:8]);
    end
    checks++;
    assert (seg === e[7:1]) else begin
      fails++;
      $error("FAIL seg t=%0d observed=%h expected=%h", t, seg, e[7:1]);
    end
    checks++;
    assert (dp === e[0]) else begin
      fails++;
      $error("FAIL dp t=%0d observed=%b expected=%b", t, dp, e[0]);
    end
    checks++;
    assert ($countones(~an) <= 1) else begin
      fails++;
      $error("FAIL an_onehot t=%0d observed=%h expected=at most one low", t, an);
    end
    if (r) begin
      t = 0;
      pending = '0;
      shown = '0;
    end else begin
      t++;
    end
  endtask

  task automatic idle(input int n, input logic [3:0] m, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, m, b);
  endtask

  initial begin
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);

    // Power-up scan of zeros, then a mid-frame load that must wait for the next frame.
    idle(40, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'h12AF, 4'h0, 1'b0);
    idle(2 * FRAME, 4'h0, 1'b0);

    // Leading-zero blanking.
    step(1'b0, 1'b1, 16'h00A0, 4'h0, 1'b1);
    idle(2 * FRAME, 4'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 4'h0, 1'b1);
    idle(2 * FRAME, 4'h0, 1'b1);

    // Load exactly on a frame boundary, then one cycle later.
    while (t % FRAME != FRAME - 1) step(1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'h5555, 4'h0, 1'b0);
    step(1'b0, 1'b1, 16'hFFFF, 4'h0, 1'b0);
    idle(2 * FRAME, 4'h0, 1'b0);

    // Decimal point on digit 2 only.
    idle(FRAME + 3, 4'b0100, 1'b0);

    // Random loads, values, decimal points and blanking.
    for (int i = 0; i < 300; i++) begin
      logic        ld;
      logic [15:0] v;
      ld = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      step(1'b0, ld, v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Reset while digit 2 is driving: scan restarts and the loaded value is lost.
    step(1'b0, 1'b1, 16'h9876, 4'h0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (((t / P_DIV) % N_DIG) == 2 && (t % P_DIV) >= P_GRD + 1 && (t % FRAME) != 0) break;
      step(1'b0, 1'b0, 16'h0000, 4'h0, 1'b0);
    end
    step(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0);
    idle(2 * FRAME, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
